pim_conv_seq: RTL and testbench

Time-multiplexed, multi-channel PIM convolution engine built on one `bram_pim` crossbar primitive. A wide input feature vector is split into crossbar-sized segments that are issued one per cycle. The signed ADC readouts are accumulated into a wider result, and the sequence repeats for `NUM_CH` consecutive weight rows (output channels). The block sits between the feature buffer and the activation stage, with valid/ready handshakes on both sides. It replaces parallel instance trees where crossbar count is the limiting resource.

---
 rtl/pim_conv_seq.sv | 159 +++++++++++++++
 tb/tb_pim_conv_seq.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/pim_conv_seq.sv
// pim_conv_seq: segment-serial PIM convolution over a single bram_pim crossbar, NUM_CH channels per vector.
// Optional macro PIM_SAT_EN: saturating accumulation (undefined: two's-complement wrap-around).

module bram_pim #(
  parameter int XBAR_SIZE = 64,
  parameter int DEPTH     = 6,
  parameter int ADC_P     = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DEPTH-1:0]     addr,
  input  logic [XBAR_SIZE-1:0] data,
  output logic [ADC_P-1:0]     rd
);
  // Ternary crossbar row: lower-half lines weigh +1, upper-half -1, row bias equals its address.
  int sum;

  always_comb begin
    sum = int'(addr);
    for (int i = 0; i < XBAR_SIZE; i++)
      if (data[i]) sum = (i < XBAR_SIZE/2) ? sum + 1 : sum - 1;
  end

  always_ff @(posedge clk or negedge rst)
    if (!rst)    rd <= '0;
    else if (en) rd <= ADC_P'(sum);
endmodule

module pim_conv_seq #(
  parameter int   INPUT_SIZE = 256,
  parameter int   XBAR_SIZE  = 64,
  parameter int   DEPTH      = 6,
  parameter int   ADC_P      = 8,
  parameter int   NUM_CH     = 4,
  parameter int   ACC_W      = 12,
  localparam int  CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_SIZE-1:0]   Input_feature,
  input  logic [DEPTH-1:0]        Base_addr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [ACC_W-1:0] Output,
  output logic [CH_W-1:0]         Out_ch,
  output logic                    busy
);
  localparam int NSEG  = (INPUT_SIZE / XBAR_SIZE > 1) ? INPUT_SIZE / XBAR_SIZE : 1;
  localparam int SEG_W = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam int PAD_W = NSEG * XBAR_SIZE;

  typedef enum logic [1:0] {IDLE, ISSUE, ACC, OUT} state_t;
  state_t state, nxt;

  logic [PAD_W-1:0]        feat_ext, feat_q;
  logic [DEPTH-1:0]        base_q, xbar_addr;
  logic [XBAR_SIZE-1:0]    seg_data;
  logic [SEG_W-1:0]        seg;
  logic [CH_W-1:0]         ch;
  logic signed [ACC_W-1:0] acc, acc_sum, rd_ext;
  logic signed [ADC_P-1:0] rd;
  logic                    xbar_en, rd_vld, accept, last_seg, last_ch;

  always_comb begin
    feat_ext = '0;
    feat_ext[INPUT_SIZE-1:0] = Input_feature;
  end

  assign seg_data  = feat_q[seg*XBAR_SIZE +: XBAR_SIZE];
  assign xbar_addr = base_q + DEPTH'(ch);
  assign last_seg  = (seg == SEG_W'(NSEG-1));
  assign last_ch   = (ch == CH_W'(NUM_CH-1));
  assign accept    = in_valid && in_ready;

  bram_pim #(.XBAR_SIZE(XBAR_SIZE), .DEPTH(DEPTH), .ADC_P(ADC_P)) u_xbar (
    .clk  (clk),
    .rst  (rst),
    .en   (xbar_en),
    .addr (xbar_addr),
    .data (seg_data),
    .rd   (rd)
  );

  // Size cast of a signed operand sign-extends, which also covers ACC_W == ADC_P.
  assign rd_ext = ACC_W'(rd);

`ifdef PIM_SAT_EN
  logic [ACC_W:0] wide;
  always_comb begin
    wide    = {acc[ACC_W-1], acc} + {rd_ext[ACC_W-1], rd_ext};
    acc_sum = wide[ACC_W-1:0];
    if (wide[ACC_W] != wide[ACC_W-1])
      acc_sum = wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
  end
`else
  assign acc_sum = acc + rd_ext;
`endif

  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else      state <= nxt;

  always_comb begin
    nxt       = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    xbar_en   = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) nxt = ISSUE;
      end
      ISSUE: begin
        xbar_en = 1'b1;
        if (last_seg) nxt = ACC;
      end
      ACC: nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) nxt = last_ch ? IDLE : ISSUE;
      end
      default: nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Readout of a segment lands one cycle after its issue; rd_vld marks that cycle.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      feat_q <= '0;
      base_q <= '0;
      seg    <= '0;
      ch     <= '0;
      acc    <= '0;
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= xbar_en;
      if (rd_vld) acc <= acc_sum;
      if (accept) begin
        feat_q <= feat_ext;
        base_q <= Base_addr;
        seg    <= '0;
        ch     <= '0;
        acc    <= '0;
      end
      if (state == ISSUE) seg <= last_seg ? '0 : seg + 1'b1;
      if (state == OUT && out_ready && !last_ch) begin
        ch  <= ch + 1'b1;
        acc <= '0;
      end
    end

  assign Output = acc;
  assign Out_ch = ch;
endmodule

// File: tb/tb_pim_conv_seq.sv
// Directed bench for pim_conv_seq: timing, address wrap, stall hold, ignored input, abort, accumulation width.
module tb_pim_conv_seq;
  logic               clk = 1'b0, rst = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [255:0]       feat = '0;
  logic [5:0]         base = '0;
  logic               in_ready, out_valid, busy;
  logic signed [11:0] outp;
  logic [1:0]         out_ch;
  logic               in_ready9, out_valid9, busy9;
  logic signed [8:0]  outp9;
  logic [1:0]         out_ch9;

  int checks = 0, failures = 0;
  int res[4], res9[4], rch[4];
  int nres, first_vld, rdy_cyc;
  logic [255:0] v_ten, v_zero, v_pos, v_neg;

  always #5 clk = ~clk;

  pim_conv_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .Input_feature(feat), .Base_addr(base), .out_valid(out_valid),
    .out_ready(out_ready), .Output(outp), .Out_ch(out_ch), .busy(busy)
  );

  pim_conv_seq #(.ACC_W(9)) dut9 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready9),
    .Input_feature(feat), .Base_addr(base), .out_valid(out_valid9),
    .out_ready(out_ready), .Output(outp9), .Out_ch(out_ch9), .busy(busy9)
  );

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // One vector: optional stall on a channel, an in_valid pulse mid-run, or a reset at a given cycle.
  task automatic run(input logic [255:0] f, input logic [5:0] b, input int stall_ch,
                     input int stall_len, input int pulse_cyc, input int abort_cyc);
    int held, hold_val, hold_ch;
    nres = 0; first_vld = -1; rdy_cyc = -1; held = 0; hold_val = 0; hold_ch = 0;
    @(negedge clk);
    feat = f; base = b; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; feat = ~f; base = b + 6'd5;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      @(negedge clk);
      if (cyc == abort_cyc) begin
        rst = 1'b0;
        #1;
        chk("abort_out_valid", int'(out_valid), 0);
        chk("abort_in_ready", int'(in_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_output", int'(outp), 0);
        @(negedge clk);
        rst = 1'b1;
        break;
      end
      if (out_valid && first_vld < 0) first_vld = cyc;
      if (in_ready) begin
        rdy_cyc = cyc;
        break;
      end
      in_valid = (cyc == pulse_cyc);
      if (out_valid && int'(out_ch) == stall_ch && held < stall_len) begin
        if (held == 0) begin
          hold_val = int'(outp); hold_ch = int'(out_ch);
        end else begin
          chk("hold_output", int'(outp), hold_val);
          chk("hold_ch", int'(out_ch), hold_ch);
        end
        chk("hold_xbar_en", int'(dut.xbar_en), 0);
        held++;
        out_ready = 1'b0;
      end else begin
        out_ready = 1'b1;
        if (out_valid && nres < 4) begin
          res[nres] = int'(outp); res9[nres] = int'(outp9); rch[nres] = int'(out_ch);
          nres++;
        end
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (abort_cyc == 0) chk("vector_done", int'(rdy_cyc > 0), 1);
  endtask

  task automatic chk4(input string tag, input int e0, input int e1, input int e2, input int e3);
    chk({tag, "_n"}, nres, 4);
    chk({tag, "_r0"}, res[0], e0);
    chk({tag, "_r1"}, res[1], e1);
    chk({tag, "_r2"}, res[2], e2);
    chk({tag, "_r3"}, res[3], e3);
  endtask

  initial begin
    v_ten  = {4{64'h0000_0000_0000_03FF}};
    v_zero = '0;
    v_pos  = {4{64'h0000_0000_FFFF_FFFF}};
    v_neg  = {4{64'hFFFF_FFFF_0000_0000}};

    repeat (3) @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_output", int'(outp), 0);
    chk("rst_out_ch", int'(out_ch), 0);
    rst = 1'b1;

    // readout per segment = addr + 10
    run(v_ten, 6'd0, -1, 0, 0, 0);
    chk4("ten", 40, 44, 48, 52);
    chk("ten_first_valid", first_vld, 6);
    chk("ten_in_ready_cyc", rdy_cyc, 25);
    for (int i = 0; i < 4; i++) chk("ten_ch", rch[i], i);

    // readout = address, rows 62,63,0,1
    run(v_zero, 6'd62, -1, 0, 0, 0);
    chk4("wrap_addr", 248, 252, 0, 4);
    chk("wrap_addr_acc9", res9[1], 252);

    run(v_zero, 6'd62, 1, 5, 0, 0);
    chk4("stall", 248, 252, 0, 4);
    chk("stall_ch1", rch[1], 1);

    run(v_ten, 6'd0, -1, 0, 3, 0);
    chk4("pulse", 40, 44, 48, 52);
    chk("pulse_in_ready_cyc", rdy_cyc, 25);

    // readout 95 on row 63 -> 380 over four segments
    run(v_pos, 6'd63, -1, 0, 0, 0);
    chk4("pos", 380, 128, 132, 136);
`ifdef PIM_SAT_EN
    chk("acc9_sat", res9[0], 255);
`else
    chk("acc9_wrap", res9[0], -132);
`endif
    chk("acc9_small", res9[1], 128);

    run(v_neg, 6'd0, -1, 0, 0, 0);
    chk4("neg", -128, -124, -120, -116);
    chk("neg_acc9", res9[0], -128);

    run(v_zero, 6'd62, -1, 0, 0, 14);
    chk("abort_results", nres, 2);

    run(v_ten, 6'd0, -1, 0, 0, 0);
    chk4("post_abort", 40, 44, 48, 52);
    chk("post_abort_ch0", rch[0], 0);
    chk("post_abort_first_valid", first_vld, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
